// File: rtl/multi_channel_clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Build option CLKDIV_SYNC_EN adds a phase-align `sync` input on the top level.
package multi_channel_clock_divider_pkg;

  localparam int unsigned MIN_DIV   = 32'd2;
  localparam int unsigned CLK_HZ    = 32'd50_000_000;
  localparam int unsigned DIV_1HZ   = CLK_HZ;
  localparam int unsigned DIV_100HZ = CLK_HZ / 32'd100;
  localparam int unsigned DIV_1KHZ  = CLK_HZ / 32'd1_000;

  // Width of a channel selector; a single channel still gets one select bit.
  function automatic int sel_width(input int channels);
    if (channels > 32'sd1) begin
      sel_width = $clog2(channels);
    end else begin
      sel_width = 32'sd1;
    end
  endfunction

endpackage

// File: rtl/multi_channel_clock_divider_channel.sv
// One divider channel: counter, active divisor, shadow divisor and registered tick/level.
// Shadow divisors are only applied at a wrap, while disabled, or on sync.
module multi_channel_clock_divider_channel
  import multi_channel_clock_divider_pkg::*;
#(
  parameter int          CNT_W       = 32'sd26,
  parameter int unsigned DEFAULT_DIV = 32'd50_000_000
)(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_divisor,
  output logic             tick,
  output logic             level,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_r, div_r, shadow_r;
  logic             pending_r, tick_r, level_r;
  logic [CNT_W-1:0] cnt_nxt_s, div_nxt_s, shadow_nxt_s, clamp_s;
  logic             pending_nxt_s, tick_nxt_s, level_nxt_s;
  logic             wrap_s, accept_s, apply_s;

  // Next-state: counting, handshake accept and shadow apply.
  always_comb begin
    wrap_s        = (cnt_r == (div_r - CNT_W'(1'b1)));
    accept_s      = cfg_we && !pending_r;
    apply_s       = pending_r && (wrap_s || !enable || sync);
    cnt_nxt_s     = '0;
    div_nxt_s     = div_r;
    shadow_nxt_s  = shadow_r;
    pending_nxt_s = pending_r;
    tick_nxt_s    = 1'b0;
    level_nxt_s   = 1'b0;
    if (cfg_divisor < CNT_W'(MIN_DIV)) begin
      clamp_s = CNT_W'(MIN_DIV);
    end else begin
      clamp_s = cfg_divisor;
    end
    if (enable && !sync) begin
      tick_nxt_s  = wrap_s;
      level_nxt_s = (cnt_r >= {1'b0, div_r[CNT_W-1:1]});
      if (wrap_s) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_nxt_s = '0;
    end
    // accept requires !pending and apply requires pending, so they never collide
    if (apply_s) begin
      div_nxt_s     = shadow_r;
      pending_nxt_s = 1'b0;
    end else if (accept_s) begin
      shadow_nxt_s  = clamp_s;
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      div_r     <= CNT_W'(DEFAULT_DIV);
      shadow_r  <= '0;
      pending_r <= 1'b0;
      tick_r    <= 1'b0;
      level_r   <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      div_r     <= div_nxt_s;
      shadow_r  <= shadow_nxt_s;
      pending_r <= pending_nxt_s;
      tick_r    <= tick_nxt_s;
      level_r   <= level_nxt_s;
    end
  end

  assign tick    = tick_r;
  assign level   = level_r;
  assign pending = pending_r;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// N-channel programmable clock divider with a valid/ready divisor reload port.
// Define CLKDIV_SYNC_EN to add the `sync` input that phase-aligns all channels.
module multi_channel_clock_divider
  import multi_channel_clock_divider_pkg::*;
#(
  parameter int          CHANNELS    = 32'sd4,
  parameter int          CNT_W       = 32'sd26,
  parameter int unsigned DEFAULT_DIV = 32'd50_000_000,
  parameter int          SEL_W       = sel_width(CHANNELS)
)(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SEL_W-1:0]    cfg_channel,
  input  logic [CNT_W-1:0]    cfg_divisor,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pending
);

  logic                sync_s;
  logic [CHANNELS-1:0] cfg_we_s;

`ifdef CLKDIV_SYNC_EN
  assign sync_s = sync;
`else
  assign sync_s = 1'b0;
`endif

  // Config demux and ready mux; out-of-range selects are always ready and dropped.
  always_comb begin
    cfg_we_s  = '0;
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_channel == SEL_W'(i)) begin
        cfg_we_s[i] = cfg_valid;
        cfg_ready   = ~pending[i];
      end else begin
        cfg_we_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    multi_channel_clock_divider_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable[g]),
      .sync        (sync_s),
      .cfg_we      (cfg_we_s[g]),
      .cfg_divisor (cfg_divisor),
      .tick        (tick[g]),
      .level       (level[g]),
      .pending     (pending[g])
    );
  end

endmodule
